// File: rtl/pipe_stall_arbiter_if.sv
// Handshake bundle between two pipeline output stages, the shared consumer and the arbiter.
// The slave modport is the arbiter; master is the pipeline/consumer side.
interface pipe_stall_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic [DATA_W-1:0] p1_data;
  logic [DATA_W-1:0] p2_data;
  logic [1:0]        p_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_src;
  logic              global_stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output p1_data, p2_data, p_valid, out_ready,
    input  out_data, out_valid, out_src, global_stall, stall_count
  );

  modport slave (
    input  p1_data, p2_data, p_valid, out_ready,
    output out_data, out_valid, out_src, global_stall, stall_count
  );
endinterface

// File: rtl/pipe_stall_arbiter.sv
// Two one-entry lane buffers drained round-robin into one consumer port; raises global_stall
// whenever the buffers cannot absorb a new result this cycle and counts stalled cycles.
module pipe_stall_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  pipe_stall_arbiter_if.slave bus
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e            r_state;
  logic [1:0]        r_buf_full;
  logic [DATA_W-1:0] r_buf_data0;
  logic [DATA_W-1:0] r_buf_data1;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_stall_count;

  logic              w_sel;
  logic              w_out_valid;
  logic              w_stall;
  logic              w_drain;
  logic [1:0]        w_cap;
  logic [1:0]        w_full_nxt;

  always_comb begin
    case (r_buf_full)
      2'b01:   w_sel = 1'b0;
      2'b10:   w_sel = 1'b1;
      2'b11:   w_sel = ~r_last_grant;
      default: w_sel = 1'b0;
    endcase
    w_out_valid = |r_buf_full;
    // One free slot is only usable if the full one drains this cycle.
    w_stall     = (&r_buf_full) | ((^r_buf_full) & ~bus.out_ready);
    w_drain     = w_out_valid & bus.out_ready;
    w_cap       = w_stall ? 2'b00 : bus.p_valid;
    w_full_nxt  = r_buf_full;
    if (w_drain) w_full_nxt[w_sel] = 1'b0;
    // Capture overrides a same-lane drain.
    w_full_nxt  = w_full_nxt | w_cap;
  end

  assign bus.out_valid    = w_out_valid;
  assign bus.out_data     = !w_out_valid ? '0 : (w_sel ? r_buf_data1 : r_buf_data0);
  assign bus.out_src      = w_sel;
  assign bus.global_stall = w_stall;
  assign bus.stall_count  = r_stall_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_buf_full    <= 2'b00;
      r_buf_data0   <= '0;
      r_buf_data1   <= '0;
      r_last_grant  <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_buf_full <= w_full_nxt;
      if (w_cap[0]) r_buf_data0 <= bus.p1_data;
      if (w_cap[1]) r_buf_data1 <= bus.p2_data;
      if (w_drain) r_last_grant <= w_sel;
      if (w_stall && (r_stall_count != CntMax)) r_stall_count <= r_stall_count + 1'b1;
      case (r_state)
        StIdle:  if (|w_cap) r_state <= StBusy;
        StBusy:  if (w_full_nxt == 2'b00) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_arbiter.sv
// Bench for pipe_stall_arbiter: vector table plus hand sequences, with per-lane ordering
// scoreboard and a narrow-counter instance for saturation.
module tb_pipe_stall_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_stall_arbiter_if #(.DATA_W(32), .CNT_W(16)) bus  ();
  pipe_stall_arbiter_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

  pipe_stall_arbiter #(.DATA_W(32), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipe_stall_arbiter #(.DATA_W(32), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  typedef struct {
    bit          rst;
    logic [1:0]  pv;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_src;
    logic        e_stall;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t        vec[40];
  int          n_vec   = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic addv(input bit rst, input logic [1:0] pv, input logic [31:0] d1,
                      input logic [31:0] d2, input logic rdy, input logic ev,
                      input logic [31:0] ed, input logic es, input logic est,
                      input logic [15:0] ec);
    vec[n_vec] = '{rst, pv, d1, d2, rdy, ev, ed, es, est, ec};
    n_vec++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.p_valid = 2'b00; bus.p1_data = '0; bus.p2_data = '0; bus.out_ready = 1'b0;
    bus4.p_valid = 2'b00; bus4.p1_data = '0; bus4.p2_data = '0; bus4.out_ready = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [1:0] pv, input logic [31:0] d1, input logic [31:0] d2,
                       input logic rdy);
    @(negedge clk);
    bus.p_valid = pv; bus.p1_data = d1; bus.p2_data = d2; bus.out_ready = rdy;
    #1;
  endtask

  task automatic score(input string tag);
    if (bus.out_valid && bus.out_ready) begin
      if (bus.out_src == 1'b0) begin
        if (q0.size() == 0) check({tag, "_lane0_extra"}, 32'd0, 32'd1);
        else check({tag, "_lane0_data"}, bus.out_data, q0.pop_front());
      end else begin
        if (q1.size() == 0) check({tag, "_lane1_extra"}, 32'd0, 32'd1);
        else check({tag, "_lane1_data"}, bus.out_data, q1.pop_front());
      end
    end
    if (!bus.global_stall) begin
      if (bus.p_valid[0]) q0.push_back(bus.p1_data);
      if (bus.p_valid[1]) q1.push_back(bus.p2_data);
    end
  endtask

  initial begin
    logic        exp_src;
    int          k0;
    int          k1;
    bit          cap;

    bus.p_valid = 2'b00; bus.p1_data = '0; bus.p2_data = '0; bus.out_ready = 1'b0;
    bus4.p_valid = 2'b00; bus4.p1_data = '0; bus4.p2_data = '0; bus4.out_ready = 1'b0;

    // Simultaneous results: lane 1 first after reset, then lane 0.
    addv(1, 2'b11, 32'hA, 32'hB, 1, 0, 32'h0, 0, 0, 0);
    addv(0, 2'b00, 32'h0, 32'h0, 1, 1, 32'hB, 1, 1, 0);
    addv(0, 2'b00, 32'h0, 32'h0, 1, 1, 32'hA, 0, 0, 1);
    addv(0, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 0, 0, 1);
    // Single-lane streaming at full rate.
    addv(1, 2'b01, 32'h10, 32'h0, 1, 0, 32'h0,  0, 0, 0);
    addv(0, 2'b01, 32'h11, 32'h0, 1, 1, 32'h10, 0, 0, 0);
    addv(0, 2'b01, 32'h12, 32'h0, 1, 1, 32'h11, 0, 0, 0);
    addv(0, 2'b00, 32'h0,  32'h0, 1, 1, 32'h12, 0, 0, 0);
    addv(0, 2'b00, 32'h0,  32'h0, 1, 0, 32'h0,  0, 0, 0);
    // Consumer backpressure for four cycles.
    addv(1, 2'b01, 32'h5, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    addv(0, 2'b00, 32'h0, 32'h0, 0, 1, 32'h5, 0, 1, 0);
    addv(0, 2'b00, 32'h0, 32'h0, 0, 1, 32'h5, 0, 1, 1);
    addv(0, 2'b00, 32'h0, 32'h0, 0, 1, 32'h5, 0, 1, 2);
    addv(0, 2'b00, 32'h0, 32'h0, 0, 1, 32'h5, 0, 1, 3);
    addv(0, 2'b00, 32'h0, 32'h0, 1, 1, 32'h5, 0, 0, 4);
    addv(0, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 0, 0, 4);
    // Same-lane capture and drain in one cycle keeps the buffer full with new data.
    addv(1, 2'b01, 32'h20, 32'h0,  1, 0, 32'h0,  0, 0, 0);
    addv(0, 2'b01, 32'h21, 32'h0,  1, 1, 32'h20, 0, 0, 0);
    addv(0, 2'b10, 32'h0,  32'h30, 1, 1, 32'h21, 0, 0, 0);
    addv(0, 2'b00, 32'h0,  32'h0,  1, 1, 32'h30, 1, 0, 0);
    addv(0, 2'b00, 32'h0,  32'h0,  1, 0, 32'h0,  0, 0, 0);

    for (int i = 0; i < n_vec; i++) begin
      if (vec[i].rst) do_reset();
      drive(vec[i].pv, vec[i].d1, vec[i].d2, vec[i].rdy);
      check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(vec[i].e_valid));
      check($sformatf("v%0d_data", i), bus.out_data, vec[i].e_data);
      check($sformatf("v%0d_src", i), 32'(bus.out_src), 32'(vec[i].e_src));
      check($sformatf("v%0d_stall", i), 32'(bus.global_stall), 32'(vec[i].e_stall));
      check($sformatf("v%0d_cnt", i), 32'(bus.stall_count), 32'(vec[i].e_cnt));
      score($sformatf("v%0d", i));
    end

    // Asynchronous reset mid-cycle with a buffered, stalled result.
    do_reset();
    drive(2'b01, 32'h33, 32'h0, 1'b0);
    drive(2'b00, 32'h0, 32'h0, 1'b0);
    check("areset_pre_valid", 32'(bus.out_valid), 32'd1);
    check("areset_pre_stall", 32'(bus.global_stall), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("areset_valid", 32'(bus.out_valid), 32'd0);
    check("areset_data", bus.out_data, 32'd0);
    check("areset_src", 32'(bus.out_src), 32'd0);
    check("areset_stall", 32'(bus.global_stall), 32'd0);
    check("areset_cnt", 32'(bus.stall_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 32'h0, 32'h0, 1'(i % 2));
      check($sformatf("idle%0d_valid", i), 32'(bus.out_valid), 32'd0);
      check($sformatf("idle%0d_stall", i), 32'(bus.global_stall), 32'd0);
    end

    // Fairness: both lanes offer data every cycle; held while stalled.
    do_reset();
    k0 = 0; k1 = 0; exp_src = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive(2'b11, 32'h100 + 32'(k0), 32'h200 + 32'(k1), 1'b1);
      if (bus.out_valid) begin
        check($sformatf("fair_src%0d", c), 32'(bus.out_src), 32'(exp_src));
        exp_src = ~exp_src;
      end
      cap = !bus.global_stall;
      score("fair");
      if (cap) begin k0++; k1++; end
    end
    for (int c = 0; c < 10; c++) begin
      drive(2'b00, 32'h0, 32'h0, 1'b1);
      if (!bus.out_valid) break;
      check($sformatf("drain_src%0d", c), 32'(bus.out_src), 32'(exp_src));
      exp_src = ~exp_src;
      score("drain");
    end
    check("fair_captures", 32'(k0), 32'd10);
    check("fair_q0_empty", 32'(q0.size()), 32'd0);
    check("fair_q1_empty", 32'(q1.size()), 32'd0);

    // Saturation on the 4-bit counter instance.
    do_reset();
    @(negedge clk);
    bus4.p_valid = 2'b01; bus4.p1_data = 32'h7; bus4.out_ready = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      bus4.p_valid = 2'b00;
      #1;
      if (i == 0)  check("sat_stall", 32'(bus4.global_stall), 32'd1);
      if (i == 14) check("sat_cnt14", 32'(bus4.stall_count), 32'd14);
      if (i == 15) check("sat_cnt15", 32'(bus4.stall_count), 32'd15);
      if (i == 20) check("sat_cnt_hold", 32'(bus4.stall_count), 32'd15);
    end
    check("sat_data", bus4.out_data, 32'h7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
